// File: rtl/rep_link_pkg.sv
// Shared definitions for the repetition-coded serial bit link.
// Used by the transmit encoder (rep3_serial_encoder) and by the
// majority-vote receiver on the other end of the channel.
//   link_state_e : IDLE / SEND frame states
//   DEF_DATA_W   : default word width
//   DEF_REP      : default number of copies per data bit (odd)
//   cnt_width()  : counter width for a counter spanning n values (min 1)
package rep_link_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } link_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REP    = 3;

  function automatic int cnt_width(input int n_values);
    return (n_values <= 1) ? 1 : $clog2(n_values);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter, 0..MAX, with synchronous clear.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to 0 (wins over inc)
//   inc        : advance by one; MAX rolls back to 0
//   count      : current value
//   at_max     : count == MAX
module mod_counter
  import rep_link_pkg::*;
#(
  parameter int MAX = 1,
  localparam int W  = cnt_width(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= at_max ? '0 : r_count + 1'b1;
    end
  end

  assign count  = r_count;
  assign at_max = (r_count == MAX_V);

endmodule

// File: rtl/rep3_serial_encoder.sv
// Transmit side of the repetition-coded bit link. Accepts a DATA_W-bit
// word over a valid/ready handshake and sends it MSB-first, each bit
// repeated REP times, over a valid/ready serial channel with a frame-end
// marker on the final copy of the final bit.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a word; in_ready high, no serial output
// SEND  | shifting out the held word; tx_valid/busy high
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : word handshake, in_data sampled on accept
//   tx_valid/tx_ready   : serial handshake for tx_bit
//   tx_last             : final transfer of the frame
//   busy                : frame in progress
module rep3_serial_encoder
  import rep_link_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REP    = DEF_REP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_bit,
  output logic              tx_last,
  output logic              busy
);

  localparam int REP_W = cnt_width(REP);
  localparam int BIT_W = cnt_width(DATA_W);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  link_state_e       r_state;
  link_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [REP_W-1:0]  w_rep_cnt;
  logic [BIT_W-1:0]  w_bit_cnt;
  logic              w_rep_at_max;
  logic              w_bit_at_max;
  logic              w_send;
  logic              w_accept;
  logic              w_xfer;
  logic              w_last;
  logic              w_cnt_clr;

  assign w_send    = (r_state == ST_SEND);
  assign w_accept  = in_valid & ~w_send;
  assign w_xfer    = w_send & tx_ready;
  // Decoded from registers only, so tx_last never sees tx_ready.
  assign w_last    = w_send && (w_rep_cnt == REP_LAST) && (w_bit_cnt == BIT_LAST);
  assign w_cnt_clr = w_accept | (w_xfer & w_last);

  mod_counter #(.MAX(REP - 1)) u_rep_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_cnt_clr),
    .inc    (w_xfer),
    .count  (w_rep_cnt),
    .at_max (w_rep_at_max)
  );

  // Bit index advances once the last copy of the current bit is taken.
  mod_counter #(.MAX(DATA_W - 1)) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_cnt_clr),
    .inc    (w_xfer & w_rep_at_max),
    .count  (w_bit_cnt),
    .at_max (w_bit_at_max)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    tx_valid    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        in_ready = 1'b0;
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready && w_rep_at_max && w_bit_at_max) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign tx_bit  = w_send & r_shift[DATA_W-1];
  assign tx_last = w_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= in_data;
    end else if (w_xfer && w_rep_at_max) begin
      r_shift <= r_shift << 1;
    end
  end

endmodule

// File: tb/tb_rep3_serial_encoder.sv
module tb_rep3_serial_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, tx_valid, tx_bit, tx_last, busy;

  logic       iv1 = 1'b0, tr1 = 1'b0, ir1, tv1, tb1, tl1, bz1;
  logic [3:0] dat1 = 4'h0;
  logic       iv2 = 1'b0, tr2 = 1'b0, ir2, tv2, tb2, tl2, bz2;
  logic [0:0] dat2 = 1'b0;

  rep3_serial_encoder #(.DATA_W(8), .REP(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_bit(tx_bit), .tx_last(tx_last), .busy(busy));

  rep3_serial_encoder #(.DATA_W(4), .REP(1)) u_w4r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_data(dat1), .tx_valid(tv1), .tx_ready(tr1),
    .tx_bit(tb1), .tx_last(tl1), .busy(bz1));

  rep3_serial_encoder #(.DATA_W(1), .REP(5)) u_w1r5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .in_data(dat2), .tx_valid(tv2), .tx_ready(tr2),
    .tx_bit(tb2), .tx_last(tl2), .busy(bz2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 8x3 instance: the frame is simply the list of
  // serial bits still owed to the channel.
  logic        mq[$];
  bit          m_ok = 1'b0;
  logic [63:0] cap = '0;
  int          cap_n = 0;
  int          last_cnt = 0;

  always @(negedge clk) begin
    if (m_ok && rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() == 0));
      chk("tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
      chk("busy",     32'(busy),     32'(mq.size() != 0));
      chk("tx_bit",   32'(tx_bit),   32'((mq.size() != 0) ? mq[0] : 1'b0));
      chk("tx_last",  32'(tx_last),  32'(mq.size() == 1));
      if (tx_valid && tx_ready) begin
        cap = {cap[62:0], tx_bit};
        cap_n++;
        if (tx_last) last_cnt++;
      end
    end
    if (!rst_n) begin
      mq.delete();
      m_ok = 1'b1;
    end else if (m_ok) begin
      if (mq.size() == 0) begin
        if (in_valid)
          for (int i = 7; i >= 0; i--)
            for (int r = 0; r < 3; r++) mq.push_back(in_data[i]);
      end else if (tx_ready) begin
        void'(mq.pop_front());
      end
    end
  end

  // Majority-vote receivers for the two parameter-sweep instances.
  logic [7:0] q1[$], q2[$];
  int xf[1:2], rc[1:2], ones[1:2], bc[1:2], dec_n[1:2];
  logic [7:0] wd[1:2];
  initial for (int k = 1; k <= 2; k++) begin
    xf[k] = 0; rc[k] = 0; ones[k] = 0; bc[k] = 0; dec_n[k] = 0; wd[k] = 8'h00;
  end

  task automatic sweep_obs(input int k, input int dw, input int rep,
                           input logic v, input logic r, input logic b, input logic l);
    logic [7:0] e;
    logic [7:0] mask;
    if (!(v && r)) return;
    chk($sformatf("sweep%0d_tx_last", k), 32'(l), 32'(xf[k] == dw * rep - 1));
    xf[k]++;
    ones[k] += int'(b);
    rc[k]++;
    if (rc[k] == rep) begin
      wd[k] = {wd[k][6:0], (ones[k] * 2 > rep)};
      bc[k]++; rc[k] = 0; ones[k] = 0;
    end
    if (bc[k] == dw) begin
      mask = 8'((1 << dw) - 1);
      if (k == 1) e = (q1.size() != 0) ? q1.pop_front() : 8'hxx;
      else        e = (q2.size() != 0) ? q2.pop_front() : 8'hxx;
      chk($sformatf("sweep%0d_word", k), 32'(wd[k] & mask), 32'(e));
      dec_n[k]++;
      bc[k] = 0; xf[k] = 0; wd[k] = 8'h00;
    end
  endtask

  always @(negedge clk) begin
    if (m_ok && rst_n) begin
      sweep_obs(1, 4, 1, tv1, tr1, tb1, tl1);
      sweep_obs(2, 1, 5, tv2, tr2, tb2, tl2);
    end
  end

  task automatic run_frame(input string nm, input logic [7:0] word, input logic [7:0] later,
                           input bit toggle, input logic [23:0] exp_bits, input int exp_cyc);
    int cyc;
    cap = '0; cap_n = 0; last_cnt = 0;
    in_valid = 1'b1; in_data = word; tx_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = later;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    chk({nm, "_bits"}, 32'(cap[23:0]), 32'(exp_bits));
    chk({nm, "_xfers"}, cap_n, 24);
    chk({nm, "_last_count"}, last_cnt, 1);
    chk({nm, "_cycles"}, cyc, exp_cyc);
  endtask

  int  cyc, n_acc, sent1, sent2;
  bit  acc, acc1, acc2;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_last",  32'(tx_last),  32'd0);
    chk("rst_tx_bit",   32'(tx_bit),   32'd0);
    tick();

    // A5 -> 111 000 111 000 000 111 000 111
    run_frame("a5_full_rate", 8'hA5, 8'hA5, 1'b0, 24'hE381C7, 24);
    tick();
    run_frame("a5_stall", 8'hA5, 8'hA5, 1'b1, 24'hE381C7, 48);
    tick();

    // Two queued words with in_valid held high throughout.
    cap = '0; cap_n = 0; last_cnt = 0;
    in_valid = 1'b1; in_data = 8'hFF; tx_ready = 1'b1;
    n_acc = 0; cyc = 0;
    while (n_acc < 2 && cyc < 200) begin
      acc = in_ready;
      tick();
      cyc++;
      if (acc) begin n_acc++; in_data = 8'h00; end
    end
    in_valid = 1'b0;
    while (!in_ready && cyc < 200) begin tick(); cyc++; end
    chk("queued_accepts", n_acc, 2);
    chk("queued_ones",  32'(cap[47:24]), 32'h00FFFFFF);
    chk("queued_zeros", 32'(cap[23:0]),  32'h00000000);
    chk("queued_xfers", cap_n, 48);
    chk("queued_last_count", last_cnt, 2);
    tick();

    // Reset in the cycle of transfer 10 of 3C.
    cap = '0; cap_n = 0; last_cnt = 0;
    in_valid = 1'b1; in_data = 8'h3C; tx_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_tx_valid", 32'(tx_valid), 32'd0);
    chk("abort_busy",     32'(busy),     32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_tx_last",  32'(tx_last),  32'd0);
    chk("abort_xfers", cap_n, 9);
    chk("abort_last_count", last_cnt, 0);
    run_frame("after_abort_81", 8'h81, 8'h81, 1'b0, 24'hE00007, 24);
    tick();

    // in_data changes right after the accept edge.
    run_frame("data_change_0f", 8'h0F, 8'hF0, 1'b0, 24'h000FFF, 24);
    tick();

    // Parameter sweep: 1000 random words per instance, random backpressure.
    sent1 = 0; sent2 = 0;
    fork
      begin
        int c1;
        c1 = 0;
        iv1 = 1'b1; dat1 = 4'($urandom);
        while (sent1 < 1000 && c1 < 20000) begin
          @(negedge clk);
          acc1 = iv1 && ir1;
          if (acc1) begin q1.push_back(8'(dat1)); sent1++; end
          @(posedge clk); #1;
          if (acc1) dat1 = 4'($urandom);
          tr1 = ($urandom_range(0, 3) != 0);
          c1++;
        end
        iv1 = 1'b0;
      end
      begin
        int c2;
        c2 = 0;
        iv2 = 1'b1; dat2 = 1'($urandom_range(0, 1));
        while (sent2 < 1000 && c2 < 20000) begin
          @(negedge clk);
          acc2 = iv2 && ir2;
          if (acc2) begin q2.push_back(8'(dat2)); sent2++; end
          @(posedge clk); #1;
          if (acc2) dat2 = 1'($urandom_range(0, 1));
          tr2 = ($urandom_range(0, 3) != 0);
          c2++;
        end
        iv2 = 1'b0;
      end
    join
    tr1 = 1'b1; tr2 = 1'b1;
    repeat (10) tick();
    chk("sweep1_sent", sent1, 1000);
    chk("sweep2_sent", sent2, 1000);
    chk("sweep1_decoded", dec_n[1], 1000);
    chk("sweep2_decoded", dec_n[2], 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
